spi_a2d_model: RTL and testbench
================================

Name: spi_a2d_model

Overview:
- Parametrised, self-checking-friendly model of an SPI A2D converter used as a bench-side slave.
- Successor to the fixed 8-channel load-cell/battery A2D model, generalised in channel count, resolution and frame length.
- Channel values are loaded at run time through a write port, so one bench can sweep ld_cell_lft, ld_cell_rght and battery without recompiling.
- Sits on the DUT's A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO bus.

Parameters:
- NUM_CH, 8: number of channels, 2..16.
- RES_BITS, 12: conversion result width.
- FRAME_BITS, 16: SCLK rises per transaction. Must be at least RES_BITS and at least CH_W+2.
- CH_W, $clog2(NUM_CH): channel-index width (derived, localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock domain, asynchronous, active-low
- SS_n  in  1  SPI slave select, active-low
- SCLK  in  1  SPI clock, mode 0
- MOSI  in  1  command data from DUT
- MISO  out  1  result data to DUT
- wr_en  in  1  bench write strobe for a channel value
- wr_ch  in  CH_W  channel to write
- wr_data  in  RES_BITS  value to store
- frame_done  out  1  one-clk pulse when a complete frame ends
- frame_err  out  1  one-clk pulse when a frame is aborted early
- last_ch  out  CH_W  channel decoded from the last complete frame

Behaviour:
- Reset values:
  - MISO=0, frame_done=0, frame_err=0, last_ch=0.
  - All channel registers = 0, pending channel = 0, bit counter = 0, state = IDLE.
- Input synchronisation:
  - SS_n and SCLK are double-flopped into clk, plus one flop for edge detect.
  - SCLK high and low phases must each be at least 4 clk periods.
  - Edges take effect 3 clk after the pin edge.
- State machine IDLE -> SHIFT -> IDLE.
  - IDLE to SHIFT on synchronised SS_n fall.
    - Load shift_tx = {zeros, value[pending_ch]}, right-justified in FRAME_BITS. This is a snapshot.
    - Clear the bit counter.
    - MISO = shift_tx MSB in the same cycle.
  - SHIFT, on SCLK rise: shift MOSI into shift_rx LSB and increment the bit counter.
  - SHIFT, on SCLK fall: shift shift_tx left and drive the new MSB on MISO.
  - SHIFT, on SS_n rise:
    - Bit counter == FRAME_BITS: pending_ch = last_ch = shift_rx[FRAME_BITS-3 -: CH_W]; pulse frame_done.
    - Bit counter != FRAME_BITS: pulse frame_err; pending_ch and last_ch unchanged.
    - Either case: return to IDLE, MISO=0.
- Pipelining: the result returned in frame N is for the channel commanded in frame N-1. The first frame after reset returns channel 0.
- Decoded channel index >= NUM_CH: store it, but the data returned is 0.
- SCLK edges while in IDLE are ignored. MOSI bits beyond the channel field are don't-care.
- wr_en: the channel register updates on the next clk edge. wr_ch >= NUM_CH is ignored.
  - A write during SHIFT does not alter the in-flight snapshot; it takes effect from the next SS_n fall.
- SS_n fall and SS_n rise cannot occur in the same synchronised cycle. If SCLK and SS_n edges coincide, the SS_n edge wins and the SCLK edge is dropped.
- rst_n asserted mid-frame: immediate return to reset values. The first SS_n fall after release starts a fresh frame; no frame_err is reported.

Optional Feature:
- Macro: A2D_NOISE_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1 at reset) advances each SS_n fall.
  - Its low 3 bits, interpreted signed (-4..+3), are added to the snapshot value.
  - The sum saturates to 0..(2^RES_BITS-1).
- Undefined: no LFSR is present and the snapshot equals the stored value exactly.

Test Plan:
- Defaults, write ch1=12'hABC then ch4=12'h123. Frame A commands ch1 and returns 16'h0000. Frame B commands ch4 and returns 16'h0ABC. Frame C returns 16'h0123. last_ch=4 after frame B. frame_done pulses 3 times.
- Frame commanding ch6, SS_n raised after 9 SCLK rises -> frame_err pulses once; next full frame returns the previously pending channel value, not ch6; last_ch unchanged.
- Write ch2=12'h7FF during frame returning ch2 (old 12'h100) -> that frame returns 16'h0100; next ch2 readback returns 16'h07FF.
- Assert rst_n low after 5 SCLK rises -> MISO=0, last_ch=0, no pulses; next frame returns ch0 = 16'h0000.
- NUM_CH=5, command ch7 -> last_ch=7; following frame returns 16'h0000.
- With A2D_NOISE_EN, ch0=12'hFFF, 64 reads -> every result in 12'hFFB..12'hFFF, never wraps; ch0=12'h002 -> results in 12'h000..12'h005.

Source files
------------

// File: rtl/spi_a2d_model.sv
// spi_a2d_model: bench-side SPI A2D converter slave (mode 0).
// Channel values are loaded through a write port. Each frame returns the
// result for the channel commanded in the previous frame, right-justified
// in FRAME_BITS.
// Optional feature: define A2D_NOISE_EN to add saturating LFSR noise
// (-4..+3) to every returned sample.
module spi_a2d_model #(
   parameter  int NUM_CH     = 8,
   parameter  int RES_BITS   = 12,
   parameter  int FRAME_BITS = 16,
   localparam int CH_W       = $clog2(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                SS_n,
   input  logic                SCLK,
   input  logic                MOSI,
   output logic                MISO,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [RES_BITS-1:0] wr_data,
   output logic                frame_done,
   output logic                frame_err,
   output logic [CH_W-1:0]     last_ch
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, nxt;

   logic ss_ff1, ss_ff2, ss_ff3;
   logic sclk_ff1, sclk_ff2, sclk_ff3;
   logic ss_fall, ss_rise, sclk_rise, sclk_fall;
   logic ld, do_rise, do_fall, end_ok, end_err;

   logic [CNT_W-1:0]      bit_cnt;
   // Only the bits up to the channel field are kept; higher command bits
   // are don't-care and would fall off the top anyway.
   logic [FRAME_BITS-3:0] shift_rx;
   // MSB of the snapshot goes straight to MISO at load, so the tx register
   // only holds the remaining bits.
   logic [FRAME_BITS-2:0] shift_tx;
   logic [CH_W-1:0]       pending_ch;
   logic [CH_W-1:0]       rx_ch;
   logic [RES_BITS-1:0]   ch_reg [2**CH_W];
   logic [RES_BITS-1:0]   sel_val, snap_val;
   logic [FRAME_BITS-1:0] snap;

   // Double-flop SS_n/SCLK into clk, third flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_ff1   <= 1'b1;
         ss_ff2   <= 1'b1;
         ss_ff3   <= 1'b1;
         sclk_ff1 <= 1'b0;
         sclk_ff2 <= 1'b0;
         sclk_ff3 <= 1'b0;
      end else begin
         ss_ff1   <= SS_n;
         ss_ff2   <= ss_ff1;
         ss_ff3   <= ss_ff2;
         sclk_ff1 <= SCLK;
         sclk_ff2 <= sclk_ff1;
         sclk_ff3 <= sclk_ff2;
      end
   end

   assign ss_fall   = ss_ff3 & ~ss_ff2;
   assign ss_rise   = ~ss_ff3 & ss_ff2;
   assign sclk_rise = ~sclk_ff3 & sclk_ff2;
   assign sclk_fall = sclk_ff3 & ~sclk_ff2;
   assign rx_ch     = shift_rx[FRAME_BITS-3 -: CH_W];

   // Out-of-range channels are never written, but guard the read explicitly
   always_comb begin
      sel_val = '0;
      if (32'(pending_ch) < NUM_CH) sel_val = ch_reg[pending_ch];
   end

`ifdef A2D_NOISE_EN
   logic [15:0]         lfsr;
   logic [RES_BITS+1:0] noisy;

   // Galois LFSR (x^16+x^14+x^13+x^11+1), one step per frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  lfsr <= 16'hACE1;
      else if (ld) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Add signed low 3 LFSR bits; two guard bits flag underflow/overflow
   always_comb begin
      noisy = {2'b00, sel_val} + {{(RES_BITS-1){lfsr[2]}}, lfsr[2:0]};
      if (noisy[RES_BITS+1])   snap_val = '0;
      else if (noisy[RES_BITS]) snap_val = '1;
      else                      snap_val = noisy[RES_BITS-1:0];
   end
`else
   assign snap_val = sel_val;
`endif

   // Right-justify the sample in the frame
   always_comb begin
      snap                 = '0;
      snap[RES_BITS-1:0]   = snap_val;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next state and per-cycle controls; SS_n edges win over SCLK edges
   always_comb begin
      nxt     = state;
      ld      = 1'b0;
      do_rise = 1'b0;
      do_fall = 1'b0;
      end_ok  = 1'b0;
      end_err = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               nxt = SHIFT;
               ld  = 1'b1;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               nxt = IDLE;
               if (bit_cnt == CNT_W'(FRAME_BITS)) end_ok  = 1'b1;
               else                               end_err = 1'b1;
            end else if (sclk_rise) begin
               do_rise = 1'b1;
            end else if (sclk_fall) begin
               do_fall = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // Shift datapath, channel pipeline and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MISO       <= 1'b0;
         shift_tx   <= '0;
         shift_rx   <= '0;
         bit_cnt    <= '0;
         pending_ch <= '0;
         last_ch    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= end_ok;
         frame_err  <= end_err;
         if (ld) begin
            shift_tx <= snap[FRAME_BITS-2:0];
            MISO     <= snap[FRAME_BITS-1];
            bit_cnt  <= '0;
         end
         if (do_rise) begin
            shift_rx <= {shift_rx[FRAME_BITS-4:0], MOSI};
            bit_cnt  <= bit_cnt + CNT_W'(1);
         end
         if (do_fall) begin
            MISO     <= shift_tx[FRAME_BITS-2];
            shift_tx <= shift_tx << 1;
         end
         if (end_ok) begin
            pending_ch <= rx_ch;
            last_ch    <= rx_ch;
         end
         if (end_ok || end_err) MISO <= 1'b0;
      end
   end

   // Channel value store; out-of-range writes are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**CH_W; i++) ch_reg[i] <= '0;
      end else if (wr_en && (32'(wr_ch) < NUM_CH)) begin
         ch_reg[wr_ch] <= wr_data;
      end
   end

endmodule

// File: tb/tb_spi_a2d_model.sv
// Bench for spi_a2d_model: frames are issued by tasks that push expected
// results into per-instance queues; a monitor pops and compares on every
// frame_done/frame_err pulse. A second instance uses NUM_CH=5.
module tb_spi_a2d_model;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ss_n = 1'b1, ss5_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic        wr_en = 1'b0, wr5_en = 1'b0;
   logic [2:0]  wr_ch = '0;
   logic [11:0] wr_data = '0;
   logic        miso, miso5, fd, fe, fd5, fe5;
   logic [2:0]  last_ch, last_ch5;

   typedef struct {
      logic        err;
      logic [15:0] lo;
      logic [15:0] hi;
      logic [2:0]  ch;
   } exp_t;

   exp_t        q[$];
   exp_t        q5[$];
   exp_t        e0, e5;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] rx_word = '0;

   always #5 clk = ~clk;

   spi_a2d_model dut (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
      .MISO(miso), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .frame_done(fd), .frame_err(fe), .last_ch(last_ch)
   );

   spi_a2d_model #(.NUM_CH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .SS_n(ss5_n), .SCLK(sclk), .MOSI(mosi),
      .MISO(miso5), .wr_en(wr5_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .frame_done(fd5), .frame_err(fe5), .last_ch(last_ch5)
   );

   task automatic report(input string nm, input logic [31:0] act,
                         input logic [31:0] req, input bit ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic exp_t mk(input logic err, input logic [15:0] lo,
                               input logic [15:0] hi, input logic [2:0] ch);
      exp_t e;
      e.err = err; e.lo = lo; e.hi = hi; e.ch = ch;
      return e;
   endfunction

   // Channel in bits [13:11]; surrounding bits are filler the slave ignores
   function automatic logic [15:0] cmd(input logic [2:0] ch);
      return {2'b10, ch, 11'h2A5};
   endfunction

   task automatic wr(input bit sel, input logic [2:0] ch, input logic [11:0] d);
      wr_ch = ch; wr_data = d;
      if (sel) wr5_en = 1'b1; else wr_en = 1'b1;
      #10;
      wr_en = 1'b0; wr5_en = 1'b0;
   endtask

   // Mode-0 master: sample MISO just before each SCLK rise, change MOSI after fall
   task automatic frame(input bit sel, input logic [15:0] c, input int nrise, input exp_t e);
      if (sel) q5.push_back(e); else q.push_back(e);
      rx_word = '0;
      if (sel) ss5_n = 1'b0; else ss_n = 1'b0;
      for (int i = 0; i < nrise; i++) begin
         mosi = c[15-i];
         #80;
         rx_word = {rx_word[14:0], (sel ? miso5 : miso)};
         sclk = 1'b1;
         #80;
         sclk = 1'b0;
      end
      #80;
      ss_n = 1'b1; ss5_n = 1'b1;
      #200;
   endtask

   // Scoreboard monitor: pop and compare on every completion/abort pulse
   always @(negedge clk) begin
      if (fd || fe) begin
         if (q.size() == 0) report("unexpected_pulse", {30'd0, fd, fe}, 32'd0, 1'b0);
         else begin
            e0 = q.pop_front();
            report("pulse_kind", {31'd0, fe}, {31'd0, e0.err}, fe == e0.err);
            report("last_ch", {29'd0, last_ch}, {29'd0, e0.ch}, last_ch == e0.ch);
            if (!e0.err)
               report("miso_word", {16'd0, rx_word}, {16'd0, e0.lo},
                      rx_word >= e0.lo && rx_word <= e0.hi);
         end
      end
      if (fd5 || fe5) begin
         if (q5.size() == 0) report("unexpected_pulse5", {30'd0, fd5, fe5}, 32'd0, 1'b0);
         else begin
            e5 = q5.pop_front();
            report("pulse_kind5", {31'd0, fe5}, {31'd0, e5.err}, fe5 == e5.err);
            report("last_ch5", {29'd0, last_ch5}, {29'd0, e5.ch}, last_ch5 == e5.ch);
            if (!e5.err)
               report("miso_word5", {16'd0, rx_word}, {16'd0, e5.lo},
                      rx_word >= e5.lo && rx_word <= e5.hi);
         end
      end
   end

   initial begin
      #20;
      report("rst_miso", {31'd0, miso}, 32'd0, miso == 1'b0);
      report("rst_last_ch", {29'd0, last_ch}, 32'd0, last_ch == 3'd0);
      report("rst_pulses", {30'd0, fd, fe}, 32'd0, {fd, fe} == 2'b00);
      #10 rst_n = 1'b1;
      #20;

`ifdef A2D_NOISE_EN
      wr(0, 3'd0, 12'hFFF);
      for (int i = 0; i < 64; i++) frame(0, cmd(3'd0), 16, mk(0, 16'h0FFB, 16'h0FFF, 3'd0));
      wr(0, 3'd0, 12'h002);
      for (int i = 0; i < 64; i++) frame(0, cmd(3'd0), 16, mk(0, 16'h0000, 16'h0005, 3'd0));
`else
      wr(0, 3'd1, 12'hABC);
      wr(0, 3'd4, 12'h123);
      wr(0, 3'd2, 12'h100);
      wr(0, 3'd5, 12'hFFF);
      frame(0, cmd(3'd1), 16, mk(0, 16'h0000, 16'h0000, 3'd1));
      frame(0, cmd(3'd4), 16, mk(0, 16'h0ABC, 16'h0ABC, 3'd4));
      frame(0, cmd(3'd2), 16, mk(0, 16'h0123, 16'h0123, 3'd2));
      // aborted after 9 rises: error pulse, pending/last stay at ch2
      frame(0, cmd(3'd6), 9, mk(1, 16'h0000, 16'h0000, 3'd2));
      // mid-frame write to ch2 must not disturb the in-flight snapshot
      fork
         frame(0, cmd(3'd2), 16, mk(0, 16'h0100, 16'h0100, 3'd2));
         begin #400; wr(0, 3'd2, 12'h7FF); end
      join
      frame(0, cmd(3'd5), 16, mk(0, 16'h07FF, 16'h07FF, 3'd5));

      // reset mid-frame after 5 rises; ch5 snapshot 0x0FFF puts a 1 on MISO
      ss_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mosi = cmd(3'd3)[15-i];
         #80 sclk = 1'b1;
         #80 sclk = 1'b0;
      end
      #40;
      report("pre_rst_miso", {31'd0, miso}, 32'd1, miso == 1'b1);
      rst_n = 1'b0;
      #20;
      report("midrst_miso", {31'd0, miso}, 32'd0, miso == 1'b0);
      report("midrst_last_ch", {29'd0, last_ch}, 32'd0, last_ch == 3'd0);
      ss_n = 1'b1;
      #100 rst_n = 1'b1;
      #100;
      frame(0, cmd(3'd1), 16, mk(0, 16'h0000, 16'h0000, 3'd1));
      frame(0, cmd(3'd0), 16, mk(0, 16'h0000, 16'h0000, 3'd0));

      // NUM_CH=5 instance: out-of-range command stored, returns zero
      wr(1, 3'd0, 12'h555);
      wr(1, 3'd7, 12'hAAA);
      frame(1, cmd(3'd7), 16, mk(0, 16'h0555, 16'h0555, 3'd7));
      frame(1, cmd(3'd0), 16, mk(0, 16'h0000, 16'h0000, 3'd0));
      frame(1, cmd(3'd0), 16, mk(0, 16'h0555, 16'h0555, 3'd0));
`endif

      #200;
      report("queues_drained", q.size() + q5.size(), 32'd0, (q.size() + q5.size()) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
